imm_issue_ctrl: RTL

IMM_ISSUE_CTRL -- requirements
Module: imm_issue_ctrl

---
 rtl/imm_issue_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/imm_issue_ctrl.sv
// Immediate-issue controller: holds at most one instruction and issues it to the
// immediate extender as one beat (scalar) or VEC_BEATS beats (vector).
module imm_issue_ctrl #(
    parameter int VEC_BEATS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [26:0]                  out_field,
    output logic [1:0]                   out_sel,
    output logic [4:0]                   out_opcode,
    output logic [$clog2(VEC_BEATS)-1:0] out_beat,
    output logic                         out_last,
    output logic [CNT_W-1:0]             issued_cnt
);

    localparam int BEAT_W = $clog2(VEC_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(VEC_BEATS - 1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SCALAR = 2'd1,
        VECTOR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_instr;
    logic [BEAT_W-1:0]  r_beat;
    logic [BEAT_W-1:0]  w_beat_nxt;
    logic [CNT_W-1:0]   r_cnt;

    logic w_valid;
    logic w_last;
    logic w_fire;
    logic w_done;
    logic w_accept;
    logic w_is_vec;

    assign w_fire   = w_valid && out_ready;
    assign w_done   = w_fire && w_last;
    assign w_accept = in_valid && in_ready;
    assign w_is_vec = !in_instr[31] && in_instr[29];

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_beat  <= '0;
            r_instr <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept)
                r_instr <= in_instr;
            if (w_done && !flush)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Flush outranks everything; a final-beat handshake may reload in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_beat_nxt  = '0;
        end else if (w_accept) begin
            w_state_nxt = w_is_vec ? VECTOR : SCALAR;
            w_beat_nxt  = '0;
        end else if (w_done) begin
            w_state_nxt = EMPTY;
            w_beat_nxt  = '0;
        end else if (w_fire) begin
            w_beat_nxt  = r_beat + BEAT_W'(1);
        end
    end

    always_comb begin
        w_valid  = (r_state != EMPTY);
        w_last   = (r_state == SCALAR) || ((r_state == VECTOR) && (r_beat == LAST_BEAT));
        in_ready = !rst && !flush && ((r_state == EMPTY) || (w_valid && out_ready && w_last));
    end

    assign out_valid  = w_valid;
    assign out_last   = w_last;
    assign out_field  = r_instr[26:0];
    assign out_sel    = r_instr[31:30];
    assign out_opcode = r_instr[31:27];
    assign out_beat   = r_beat;
    assign issued_cnt = r_cnt;

endmodule
